// File: rtl/pwm_duty_capture_8ch.sv
// -----------------------------------------------------------------------------
// pwm_duty_capture_8ch
//
// Receive side of the 8-channel 3-bit PWM link. Each input is synchronized and
// its high samples are counted over a free-running window of 2**LEVEL_W
// clocks. At the end of every window the per-channel total (0..8) is latched:
// the level is the total clamped to 7, and the full flag marks a channel that
// was high for the whole window. Because the driver period equals the window
// length, any window recovers the driver level regardless of phase.
//
// Optional build macro:
//   DEGLITCH_EN  adds a 3-tap majority filter after the synchronizer. This adds
//                two clocks of input latency and removes single-cycle pulses
//                and drops.
//
// Ports:
//   clk         single clock, all logic on posedge
//   rst         asynchronous active-high reset (release synchronously)
//   pwm_in      raw PWM inputs, asynchronous to clk
//   sel         channel select for readback
//   level_out   registered recovered level of channel sel
//   full_out    registered full flag of channel sel
//   valid       high once the first complete window has been latched
//   frame_tick  one-cycle pulse on each window latch
//   changed     one-cycle pulse with frame_tick when any level/full differs
//               from the previous window
// -----------------------------------------------------------------------------
module pwm_duty_capture_8ch #(
    parameter int CHANNELS = 8,
    parameter int LEVEL_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] pwm_in,
    input  logic [2:0]          sel,
    output logic [LEVEL_W-1:0]  level_out,
    output logic                full_out,
    output logic                valid,
    output logic                frame_tick,
    output logic                changed
);

    // One extra bit so a fully-high window (total 2**LEVEL_W) fits without wrap.
    localparam int CNT_W = LEVEL_W + 1;

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] s;

    logic [LEVEL_W-1:0]  win;
    logic                win_last;

    logic [CNT_W-1:0]    cnt      [CHANNELS];
    logic [LEVEL_W-1:0]  lvl      [CHANNELS];
    logic [CHANNELS-1:0] full;

    logic [CNT_W-1:0]    total    [CHANNELS];
    logic [LEVEL_W-1:0]  nxt_lvl  [CHANNELS];
    logic [CHANNELS-1:0] nxt_full;
    logic                any_diff;

    // Two-flop synchronizer per channel.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse sync2
    // into sync1 and remove a stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
        end
    end

`ifdef DEGLITCH_EN
    // Majority of the last three synchronized samples; a lone 1 or 0 is voted out.
    logic [CHANNELS-1:0] tap0;
    logic [CHANNELS-1:0] tap1;
    logic [CHANNELS-1:0] tap2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap0 <= '0;
            tap1 <= '0;
            tap2 <= '0;
        end else begin
            tap0 <= sync2;
            tap1 <= tap0;
            tap2 <= tap1;
        end
    end

    assign s = (tap0 & tap1) | (tap0 & tap2) | (tap1 & tap2);
`else
    assign s = sync2;
`endif

    assign win_last = (win == '1);

    // End-of-window arithmetic: the sample arriving on the last window cycle is
    // added here so it is counted in the same cycle the result is latched.
    // NOTE: every always_comb output gets a default before any condition so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        any_diff = 1'b0;
        nxt_full = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            total[i]    = cnt[i] + CNT_W'(s[i]);
            nxt_full[i] = total[i][LEVEL_W];
            // Total can only exceed the level range when it is exactly full.
            nxt_lvl[i]  = total[i][LEVEL_W] ? '1 : total[i][LEVEL_W-1:0];
            if ((nxt_lvl[i] != lvl[i]) || (nxt_full[i] != full[i])) begin
                any_diff = 1'b1;
            end
        end
    end

    // NOTE: the latched level/full arrays are small flop banks, not RAM, so they
    // are reset with everything else; a readback right after reset must be 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win        <= '0;
            full       <= '0;
            valid      <= 1'b0;
            frame_tick <= 1'b0;
            changed    <= 1'b0;
            level_out  <= '0;
            full_out   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
                lvl[i] <= '0;
            end
        end else begin
            win        <= win + LEVEL_W'(1);
            frame_tick <= win_last;
            changed    <= win_last & any_diff;

            for (int i = 0; i < CHANNELS; i++) begin
                // First cycle of a window restarts the count with this sample.
                cnt[i] <= (win == '0) ? CNT_W'(s[i]) : total[i];
            end

            if (win_last) begin
                full  <= nxt_full;
                valid <= 1'b1;
                for (int i = 0; i < CHANNELS; i++) begin
                    lvl[i] <= nxt_lvl[i];
                end
            end

            // Forward the value being latched so readback updates together with
            // frame_tick, including when sel changes in the latch cycle.
            level_out <= win_last ? nxt_lvl[sel]  : lvl[sel];
            full_out  <= win_last ? nxt_full[sel] : full[sel];
        end
    end

endmodule
